// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode definitions used by the fetch, decode and execute stages.
// The package holds the opcode and funct constants, the next-PC select codes,
// the Tnew values, the special-stall class codes, and the instruction decoder.
package mips_defs;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Next-PC select codes returned to fetch
    localparam logic [1:0] SEL_PC4 = 2'b00;
    localparam logic [1:0] SEL_NPC = 2'b01;

    // Stages remaining until the result exists
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;
    localparam logic [1:0] TNEW_3 = 2'd3;

    // Special stall classes for the multiply/divide unit
    localparam logic [1:0] SS_NONE = 2'b00;
    localparam logic [1:0] SS_MD   = 2'b01;
    localparam logic [1:0] SS_MF   = 2'b10;

    typedef enum logic [4:0] {
        I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_BNE,
        I_J, I_JAL, I_JR, I_MULT, I_MULTU, I_DIV, I_DIVU,
        I_MFHI, I_MFLO, I_MTHI, I_MTLO
    } instr_e;

    // Anything outside the supported subset decodes as a nop.
    function automatic instr_e decode_instr(input logic [31:0] ir);
        instr_e res;
        res = I_NOP;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADDU:  res = I_ADDU;
                    FN_SUBU:  res = I_SUBU;
                    FN_JR:    res = I_JR;
                    FN_MULT:  res = I_MULT;
                    FN_MULTU: res = I_MULTU;
                    FN_DIV:   res = I_DIV;
                    FN_DIVU:  res = I_DIVU;
                    FN_MFHI:  res = I_MFHI;
                    FN_MFLO:  res = I_MFLO;
                    FN_MTHI:  res = I_MTHI;
                    FN_MTLO:  res = I_MTLO;
                    default:  res = I_NOP;
                endcase
            end
            OP_J:    res = I_J;
            OP_JAL:  res = I_JAL;
            OP_BEQ:  res = I_BEQ;
            OP_BNE:  res = I_BNE;
            OP_ORI:  res = I_ORI;
            OP_LUI:  res = I_LUI;
            OP_LW:   res = I_LW;
            OP_SW:   res = I_SW;
            default: res = I_NOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of all D-stage data signals: fetch inputs, W write port, E/M forwarding
// inputs, next-PC/hazard outputs back to fetch, and the D/E register outputs.
// slave  : the decode stage itself
// master : the surrounding pipeline (or a testbench) driving it
interface decode_stage_if;
    logic [31:0] IR_F2D;
    logic [31:0] PC4_F2D;
    logic        WE_W;
    logic [4:0]  WA_W;
    logic [31:0] WD_W;
    logic        FwdValid_E;
    logic [4:0]  FwdAddr_E;
    logic [31:0] FwdData_E;
    logic        FwdValid_M;
    logic [4:0]  FwdAddr_M;
    logic [31:0] FwdData_M;
    logic [1:0]  selPC;
    logic [31:0] NPC;
    logic [1:0]  TNew_F2D;
    logic [4:0]  WhoNew_F2D;
    logic [1:0]  specialstock_D;
    logic [31:0] IR_D2E;
    logic [31:0] PC4_D2E;
    logic [31:0] RS_D2E;
    logic [31:0] RT_D2E;
    logic [31:0] EXT_D2E;
    logic [1:0]  TNew_D2E;
    logic [4:0]  WhoNew_D2E;
    logic [1:0]  specialstock_E;

    modport slave (
        input  IR_F2D, PC4_F2D, WE_W, WA_W, WD_W,
               FwdValid_E, FwdAddr_E, FwdData_E, FwdValid_M, FwdAddr_M, FwdData_M,
        output selPC, NPC, TNew_F2D, WhoNew_F2D, specialstock_D,
               IR_D2E, PC4_D2E, RS_D2E, RT_D2E, EXT_D2E, TNew_D2E, WhoNew_D2E, specialstock_E
    );

    modport master (
        output IR_F2D, PC4_F2D, WE_W, WA_W, WD_W,
               FwdValid_E, FwdAddr_E, FwdData_E, FwdValid_M, FwdAddr_M, FwdData_M,
        input  selPC, NPC, TNew_F2D, WhoNew_F2D, specialstock_D,
               IR_D2E, PC4_D2E, RS_D2E, RT_D2E, EXT_D2E, TNew_D2E, WhoNew_D2E, specialstock_E
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file with two combinational read ports and one write port.
// Ports: Clk, Reset (async, active-low, clears all registers), we/wa/wd write
// port, ra1/ra2 read addresses, rd1/rd2 read data.
// $0 always reads zero; a read of the register being written this cycle
// returns the incoming write data, so W results reach D without a bubble.
module reg_file (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs_reg [32];
    logic        wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= 32'h0;
            end
        end else if (wr_en) begin
            regs_reg[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0)            ? 32'h0 :
                 (wr_en && (wa == ra1))   ? wd    : regs_reg[ra1];
    assign rd2 = (ra2 == 5'd0)            ? 32'h0 :
                 (wr_en && (wa == ra2))   ? wd    : regs_reg[ra2];
endmodule

// File: rtl/decode_stage.sv
// D stage of the 5-stage MIPS pipeline.
// Ports: Clk, Reset (async, active-low), bus (decode_stage_if.slave) carrying
// IR/PC4 from fetch, the W write port, E/M forwarding, selPC/NPC and hazard
// info back to fetch, and the D/E pipeline register outputs.
// Operands are resolved with forwarding (E over M over register file), branch
// and jump targets are produced in the same cycle, and everything is captured
// into the D/E register on every clock edge (no stall: bubbles arrive as IR=0).
module decode_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC4 = 32'h0000_3000,
    parameter logic [4:0]  RA_REG    = 5'd31
) (
    input  logic           Clk,
    input  logic           Reset,
    decode_stage_if.slave  bus
);
    logic [31:0]      ir;
    logic [31:0]      pc4;
    logic [31:0]      pc4_plus4;
    logic [15:0]      imm;
    instr_e           instr;
    logic [1:0][4:0]  src_addr;
    logic [1:0][31:0] rf_rdata;
    logic [1:0][31:0] opnd;
    logic [31:0]      ext;
    logic [1:0]       sel_pc;
    logic [31:0]      npc;
    logic [1:0]       tnew_raw;
    logic [1:0]       tnew;
    logic [4:0]       dest;
    logic [1:0]       ss;

    logic [31:0] ir_d2e_reg, pc4_d2e_reg, rs_d2e_reg, rt_d2e_reg, ext_d2e_reg;
    logic [1:0]  tnew_d2e_reg, ss_e_reg;
    logic [4:0]  who_d2e_reg;

    assign ir          = bus.IR_F2D;
    assign pc4         = bus.PC4_F2D;
    assign pc4_plus4   = pc4 + 32'd4;
    assign imm         = ir[15:0];
    assign instr       = decode_instr(ir);
    assign src_addr[0] = ir[25:21];
    assign src_addr[1] = ir[20:16];

    reg_file u_reg_file (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (bus.WE_W),
        .wa    (bus.WA_W),
        .wd    (bus.WD_W),
        .ra1   (src_addr[0]),
        .ra2   (src_addr[1]),
        .rd1   (rf_rdata[0]),
        .rd2   (rf_rdata[1])
    );

    // Operand 0 is rs, operand 1 is rt; E is younger than M so it wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            assign opnd[gi] =
                (src_addr[gi] == 5'd0) ? 32'h0 :
                (bus.FwdValid_E && (bus.FwdAddr_E == src_addr[gi])) ? bus.FwdData_E :
                (bus.FwdValid_M && (bus.FwdAddr_M == src_addr[gi])) ? bus.FwdData_M :
                rf_rdata[gi];
        end
    endgenerate

    always_comb begin
        ext = 32'h0;
        case (instr)
            I_ORI:                    ext = {16'h0, imm};
            I_LUI:                    ext = {imm, 16'h0};
            I_LW, I_SW, I_BEQ, I_BNE: ext = {{16{imm[15]}}, imm};
            default:                  ext = 32'h0;
        endcase
    end

    always_comb begin
        sel_pc = SEL_PC4;
        npc    = pc4_plus4;
        case (instr)
            I_BEQ, I_BNE: begin
                if ((opnd[0] == opnd[1]) == (instr == I_BEQ)) begin
                    sel_pc = SEL_NPC;
                    npc    = pc4 + {{14{imm[15]}}, imm, 2'b00};
                end
            end
            I_J, I_JAL: begin
                sel_pc = SEL_NPC;
                npc    = {pc4[31:28], ir[25:0], 2'b00};
            end
            I_JR: begin
                sel_pc = SEL_NPC;
                npc    = opnd[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        tnew_raw = TNEW_0;
        dest     = 5'd0;
        ss       = SS_NONE;
        case (instr)
            I_LW:                          begin tnew_raw = TNEW_3; dest = ir[20:16]; end
            I_ADDU, I_SUBU:                begin tnew_raw = TNEW_2; dest = ir[15:11]; end
            I_MFHI, I_MFLO:                begin tnew_raw = TNEW_2; dest = ir[15:11]; ss = SS_MF; end
            I_ORI, I_LUI:                  begin tnew_raw = TNEW_2; dest = ir[20:16]; end
            I_JAL:                         begin tnew_raw = TNEW_1; dest = RA_REG; end
            I_MULT, I_MULTU, I_DIV, I_DIVU,
            I_MTHI, I_MTLO:                ss = SS_MD;
            default: ;
        endcase
        // A write to $0 is no write at all, so it must never stall anyone.
        tnew = (dest == 5'd0) ? TNEW_0 : tnew_raw;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir_d2e_reg   <= 32'h0;
            pc4_d2e_reg  <= RESET_PC4;
            rs_d2e_reg   <= 32'h0;
            rt_d2e_reg   <= 32'h0;
            ext_d2e_reg  <= 32'h0;
            tnew_d2e_reg <= TNEW_0;
            who_d2e_reg  <= 5'd0;
            ss_e_reg     <= SS_NONE;
        end else begin
            ir_d2e_reg   <= ir;
            pc4_d2e_reg  <= pc4;
            rs_d2e_reg   <= opnd[0];
            // jal carries its link value in the rt slot; E just passes it on.
            rt_d2e_reg   <= (instr == I_JAL) ? pc4_plus4 : opnd[1];
            ext_d2e_reg  <= ext;
            tnew_d2e_reg <= (tnew == TNEW_0) ? TNEW_0 : tnew - 2'd1;
            who_d2e_reg  <= dest;
            ss_e_reg     <= ss;
        end
    end

    assign bus.selPC          = sel_pc;
    assign bus.NPC            = npc;
    assign bus.TNew_F2D       = tnew;
    assign bus.WhoNew_F2D     = dest;
    assign bus.specialstock_D = ss;
    assign bus.IR_D2E         = ir_d2e_reg;
    assign bus.PC4_D2E        = pc4_d2e_reg;
    assign bus.RS_D2E         = rs_d2e_reg;
    assign bus.RT_D2E         = rt_d2e_reg;
    assign bus.EXT_D2E        = ext_d2e_reg;
    assign bus.TNew_D2E       = tnew_d2e_reg;
    assign bus.WhoNew_D2E     = who_d2e_reg;
    assign bus.specialstock_E = ss_e_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: each vector carries its inputs
// and hand-computed expected outputs; a monitor pops vectors and compares the
// combinational outputs before the clock edge and the D/E register after it.
module tb_decode_stage;
    logic clk;
    logic rst_n;

    decode_stage_if bus ();

    decode_stage dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fve;
        logic [4:0]  fae;
        logic [31:0] fde;
        logic        fvm;
        logic [4:0]  fam;
        logic [31:0] fdm;
        logic [1:0]  sel;
        logic [31:0] npc;
        logic [1:0]  tnf;
        logic [4:0]  whof;
        logic [1:0]  ssd;
        logic [31:0] ir_e;
        logic [31:0] pc4_e;
        logic [31:0] rs_e;
        logic [31:0] rt_e;
        logic [31:0] ext_e;
        logic [1:0]  tn_e;
        logic [4:0]  who_e;
        logic [1:0]  ss_e;
    } vec_t;

    vec_t sb_q[$];
    int   n_compared = 0;
    int   n_failed   = 0;
    int   n_txn      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Default expectation: a non-branching, non-writing instruction whose
    // operands and extension are zero; vectors override what differs.
    function automatic vec_t base(input logic [31:0] ir, input logic [31:0] pc4);
        vec_t v;
        v       = '0;
        v.rst_n = 1'b1;
        v.ir    = ir;
        v.pc4   = pc4;
        v.npc   = pc4 + 32'd4;
        v.ir_e  = ir;
        v.pc4_e = pc4;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n          = v.rst_n;
        bus.IR_F2D     = v.ir;
        bus.PC4_F2D    = v.pc4;
        bus.WE_W       = v.we;
        bus.WA_W       = v.wa;
        bus.WD_W       = v.wd;
        bus.FwdValid_E = v.fve;
        bus.FwdAddr_E  = v.fae;
        bus.FwdData_E  = v.fde;
        bus.FwdValid_M = v.fvm;
        bus.FwdAddr_M  = v.fam;
        bus.FwdData_M  = v.fdm;
        sb_q.push_back(v);
    endtask

    // Monitor: combinational outputs mid-low-phase, D/E outputs after the edge.
    initial begin
        vec_t cur;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                chk("selPC",          {30'h0, bus.selPC},          {30'h0, cur.sel});
                chk("NPC",            bus.NPC,                     cur.npc);
                chk("TNew_F2D",       {30'h0, bus.TNew_F2D},       {30'h0, cur.tnf});
                chk("WhoNew_F2D",     {27'h0, bus.WhoNew_F2D},     {27'h0, cur.whof});
                chk("specialstock_D", {30'h0, bus.specialstock_D}, {30'h0, cur.ssd});
                @(posedge clk);
                #1;
                chk("IR_D2E",         bus.IR_D2E,                  cur.ir_e);
                chk("PC4_D2E",        bus.PC4_D2E,                 cur.pc4_e);
                chk("RS_D2E",         bus.RS_D2E,                  cur.rs_e);
                chk("RT_D2E",         bus.RT_D2E,                  cur.rt_e);
                chk("EXT_D2E",        bus.EXT_D2E,                 cur.ext_e);
                chk("TNew_D2E",       {30'h0, bus.TNew_D2E},       {30'h0, cur.tn_e});
                chk("WhoNew_D2E",     {27'h0, bus.WhoNew_D2E},     {27'h0, cur.who_e});
                chk("specialstock_E", {30'h0, bus.specialstock_E}, {30'h0, cur.ss_e});
                $display("txn %0d ir=%h pc4=%h rst_n=%0b checked", n_txn, cur.ir, cur.pc4, cur.rst_n);
                n_txn++;
            end
        end
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus.IR_F2D = '0; bus.PC4_F2D = '0; bus.WE_W = 1'b0; bus.WA_W = '0; bus.WD_W = '0;
        bus.FwdValid_E = 1'b0; bus.FwdAddr_E = '0; bus.FwdData_E = '0;
        bus.FwdValid_M = 1'b0; bus.FwdAddr_M = '0; bus.FwdData_M = '0;

        // power-on reset
        v = base(32'h0, 32'h3000); v.rst_n = 1'b0; apply(v);
        // write $5 so the later reset has something to clear
        v = base(32'h0, 32'h3004); v.we = 1'b1; v.wa = 5'd5; v.wd = 32'h5555_5555; apply(v);
        // reset mid-stream with ori in D: D2E held at reset values, comb follows IR
        v = base(32'h3405_1234, 32'h3008); v.rst_n = 1'b0; v.tnf = 2'd2; v.whof = 5'd5;
        v.ir_e = 32'h0; v.pc4_e = 32'h3000; apply(v);
        // addu $6,$5,$0 : $5 was cleared
        v = base(32'h00A0_3021, 32'h300C); v.tnf = 2'd2; v.whof = 5'd6; v.tn_e = 2'd1; v.who_e = 5'd6; apply(v);
        // ori $5,$0,0x1234
        v = base(32'h3405_1234, 32'h3010); v.tnf = 2'd2; v.whof = 5'd5;
        v.ext_e = 32'h0000_1234; v.tn_e = 2'd1; v.who_e = 5'd5; apply(v);
        // addu $9,$8,$8 while W writes $8 (write-through)
        v = base(32'h0108_4821, 32'h3014); v.we = 1'b1; v.wa = 5'd8; v.wd = 32'hDEAD_BEEF;
        v.tnf = 2'd2; v.whof = 5'd9; v.rs_e = 32'hDEAD_BEEF; v.rt_e = 32'hDEAD_BEEF;
        v.tn_e = 2'd1; v.who_e = 5'd9; apply(v);
        // nop while W writes $2=7
        v = base(32'h0, 32'h3018); v.we = 1'b1; v.wa = 5'd2; v.wd = 32'd7; apply(v);
        // beq $1,$2,-1 with $1 forwarded from E = 7 : taken, 0x3010 - 4
        v = base(32'h1022_FFFF, 32'h3010); v.fve = 1'b1; v.fae = 5'd1; v.fde = 32'd7;
        v.sel = 2'b01; v.npc = 32'h0000_300C; v.rs_e = 32'd7; v.rt_e = 32'd7; v.ext_e = 32'hFFFF_FFFF; apply(v);
        // same beq while W writes $2=8 : not taken
        v = base(32'h1022_FFFF, 32'h3010); v.fve = 1'b1; v.fae = 5'd1; v.fde = 32'd7;
        v.we = 1'b1; v.wa = 5'd2; v.wd = 32'd8;
        v.npc = 32'h0000_3014; v.rs_e = 32'd7; v.rt_e = 32'd8; v.ext_e = 32'hFFFF_FFFF; apply(v);
        // jal 0x0000C01
        v = base(32'h0C00_0C01, 32'h3008); v.sel = 2'b01; v.npc = 32'h0000_3004;
        v.tnf = 2'd1; v.whof = 5'd31; v.rt_e = 32'h0000_300C; v.who_e = 5'd31; apply(v);
        // lw $3,-8($4)
        v = base(32'h8C83_FFF8, 32'h300C); v.tnf = 2'd3; v.whof = 5'd3;
        v.ext_e = 32'hFFFF_FFF8; v.tn_e = 2'd2; v.who_e = 5'd3; apply(v);
        // mult $8,$2
        v = base(32'h0102_0018, 32'h3010); v.ssd = 2'b01; v.ss_e = 2'b01;
        v.rs_e = 32'hDEAD_BEEF; v.rt_e = 32'd8; apply(v);
        // mflo $10
        v = base(32'h0000_5012, 32'h3014); v.ssd = 2'b10; v.ss_e = 2'b10;
        v.tnf = 2'd2; v.whof = 5'd10; v.tn_e = 2'd1; v.who_e = 5'd10; apply(v);
        // jr $31, E and M both forward $31 : E wins
        v = base(32'h03E0_0008, 32'h3018); v.fve = 1'b1; v.fae = 5'd31; v.fde = 32'h0000_4000;
        v.fvm = 1'b1; v.fam = 5'd31; v.fdm = 32'h0000_5000;
        v.sel = 2'b01; v.npc = 32'h0000_4000; v.rs_e = 32'h0000_4000; apply(v);
        // jr $31, only M forwards
        v = base(32'h03E0_0008, 32'h301C); v.fvm = 1'b1; v.fam = 5'd31; v.fdm = 32'h0000_5000;
        v.sel = 2'b01; v.npc = 32'h0000_5000; v.rs_e = 32'h0000_5000; apply(v);
        // j 0x0100000 keeps PC4[31:28]
        v = base(32'h0810_0000, 32'hA000_0000); v.sel = 2'b01; v.npc = 32'hA040_0000; apply(v);
        // lui $7,0xABCD
        v = base(32'h3C07_ABCD, 32'h3020); v.tnf = 2'd2; v.whof = 5'd7;
        v.ext_e = 32'hABCD_0000; v.tn_e = 2'd1; v.who_e = 5'd7; apply(v);
        // bne $8,$0,+2 with target wrapping past 2^32
        v = base(32'h1500_0002, 32'hFFFF_FFFC); v.sel = 2'b01; v.npc = 32'h0000_0004;
        v.rs_e = 32'hDEAD_BEEF; v.ext_e = 32'h0000_0002; apply(v);
        // addu $0,$1,$2 : dest 0 forces Tnew 0
        v = base(32'h0022_0021, 32'h3024); v.rt_e = 32'd8; apply(v);
        // sw $2,4($8)
        v = base(32'hAD02_0004, 32'h3028); v.rs_e = 32'hDEAD_BEEF; v.rt_e = 32'd8; v.ext_e = 32'd4; apply(v);
        // unknown opcode decodes as nop
        v = base(32'hFC00_0000, 32'h302C); apply(v);
        // addu $11,$2,$2 : M forwards $2, E forwards an unrelated register
        v = base(32'h0042_5821, 32'h3030); v.fve = 1'b1; v.fae = 5'd3; v.fde = 32'h0000_9999;
        v.fvm = 1'b1; v.fam = 5'd2; v.fdm = 32'h0000_1111;
        v.rs_e = 32'h0000_1111; v.rt_e = 32'h0000_1111;
        v.tnf = 2'd2; v.whof = 5'd11; v.tn_e = 2'd1; v.who_e = 5'd11; apply(v);

        repeat (3) @(negedge clk);
        n_compared++;
        if (sb_q.size() != 0) begin
            n_failed++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
